// File: rtl/bp_fe_instr_realigner.sv
// Front-end realigner: turns aligned 32-bit fetch words into one 32-bit instruction per handshake,
// expanding RVC parcels and stitching straddlers. BP_FE_REALIGN_PERF_EN adds event counters.
module bp_fe_instr_realigner
  #(parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32)
  (input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       fetch_v_i,
   input  logic [vaddr_width_p-1:0]   fetch_pc_i,
   input  logic [instr_width_p-1:0]   fetch_data_i,
   output logic                       fetch_ready_o,
   input  logic                       redirect_v_i,
   output logic [instr_width_p/2-1:0] exp_cinstr_o,
   input  logic [instr_width_p-1:0]   exp_instr_i,
   input  logic                       exp_v_i,
   output logic                       instr_v_o,
   input  logic                       instr_ready_i,
   output logic [instr_width_p-1:0]   instr_o,
   output logic [vaddr_width_p-1:0]   instr_pc_o,
   output logic                       instr_compressed_o,
`ifdef BP_FE_REALIGN_PERF_EN
   output logic [31:0]                perf_cinstr_o,
   output logic [31:0]                perf_straddle_o,
`endif
   output logic                       instr_illegal_o);

  localparam int parcel_width_lp = instr_width_p / 2;

  typedef enum logic [0:0] {EMPTY = 1'b0, RESID = 1'b1} state_e;

  state_e                       state_q, nxt_state;
  logic [parcel_width_lp-1:0]   resid_q, nxt_resid;
  logic [vaddr_width_p-1:0]     resid_pc_q, nxt_resid_pc;
  logic [parcel_width_lp-1:0]   parcel0, parcel1;
  logic                         resid_c, p0_c, p1_c, adv, accept;
  logic                         emit, emit_c, emit_ill, emit_stitch;
  logic [instr_width_p-1:0]     emit_instr;
  logic [vaddr_width_p-1:0]     emit_pc;

  assign parcel0 = fetch_data_i[parcel_width_lp-1:0];
  assign parcel1 = fetch_data_i[instr_width_p-1:parcel_width_lp];
  assign resid_c = (resid_q[1:0] != 2'b11);
  assign p0_c    = (parcel0[1:0] != 2'b11);
  assign p1_c    = (parcel1[1:0] != 2'b11);

  assign adv           = !instr_v_o || instr_ready_i;
  assign fetch_ready_o = adv && !redirect_v_i && !((state_q == RESID) && resid_c);
  assign accept        = fetch_v_i && fetch_ready_o;

  // Parcel presented to the expander: the held residue wins over the incoming word.
  always_comb begin
    if (state_q == RESID) begin
      exp_cinstr_o = resid_q;
    end else if (fetch_pc_i[1]) begin
      exp_cinstr_o = parcel1;
    end else begin
      exp_cinstr_o = parcel0;
    end
  end

  // Select the next emitted instruction and the next residue state.
  always_comb begin
    emit         = 1'b0;
    emit_instr   = exp_instr_i;
    emit_pc      = fetch_pc_i;
    emit_c       = 1'b1;
    emit_ill     = !exp_v_i;
    emit_stitch  = 1'b0;
    nxt_state    = state_q;
    nxt_resid    = resid_q;
    nxt_resid_pc = resid_pc_q;
    case (state_q)
      RESID: begin
        if (resid_c) begin
          emit      = 1'b1;
          emit_pc   = resid_pc_q;
          nxt_state = EMPTY;
        end else if (accept) begin
          // Upper half comes from the new word; the stream is assumed sequential.
          emit         = 1'b1;
          emit_instr   = {parcel0, resid_q};
          emit_pc      = resid_pc_q;
          emit_c       = 1'b0;
          emit_ill     = 1'b0;
          emit_stitch  = 1'b1;
          nxt_resid    = parcel1;
          nxt_resid_pc = resid_pc_q + vaddr_width_p'(4);
        end else begin
          nxt_state = RESID;
        end
      end
      default: begin
        if (!accept) begin
          nxt_state = EMPTY;
        end else if (!fetch_pc_i[1]) begin
          emit = 1'b1;
          if (p0_c) begin
            nxt_resid    = parcel1;
            nxt_resid_pc = fetch_pc_i + vaddr_width_p'(2);
            nxt_state    = RESID;
          end else begin
            emit_instr = fetch_data_i;
            emit_c     = 1'b0;
            emit_ill   = 1'b0;
          end
        end else if (p1_c) begin
          emit = 1'b1;
        end else begin
          nxt_resid    = parcel1;
          nxt_resid_pc = fetch_pc_i;
          nxt_state    = RESID;
        end
      end
    endcase
  end

  // Residue state and output register; redirect flushes, reset overrides everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q            <= EMPTY;
      resid_q            <= '0;
      resid_pc_q         <= '0;
      instr_v_o          <= 1'b0;
      instr_o            <= '0;
      instr_pc_o         <= '0;
      instr_compressed_o <= 1'b0;
      instr_illegal_o    <= 1'b0;
    end else if (redirect_v_i) begin
      state_q    <= EMPTY;
      resid_q    <= '0;
      resid_pc_q <= '0;
      instr_v_o  <= 1'b0;
    end else if (adv) begin
      state_q    <= nxt_state;
      resid_q    <= nxt_resid;
      resid_pc_q <= nxt_resid_pc;
      instr_v_o  <= emit;
      if (emit) begin
        instr_o            <= emit_instr;
        instr_pc_o         <= emit_pc;
        instr_compressed_o <= emit_c;
        instr_illegal_o    <= emit_ill;
      end
    end
  end

`ifdef BP_FE_REALIGN_PERF_EN
  // Event counters survive redirects and wrap naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_cinstr_o   <= 32'd0;
      perf_straddle_o <= 32'd0;
    end else if (!redirect_v_i && adv && emit) begin
      if (emit_c) perf_cinstr_o <= perf_cinstr_o + 32'd1;
      if (emit_stitch) perf_straddle_o <= perf_straddle_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_instr_realigner.sv
// Self-checking bench for bp_fe_instr_realigner: directed scenarios plus a randomized parcel-stream scoreboard.
module tb_bp_fe_instr_realigner;
  localparam int VW = 39;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, fetch_v_i, fetch_ready_o, redirect_v_i, exp_v_i;
  logic          instr_v_o, instr_ready_i, instr_compressed_o, instr_illegal_o;
  logic [VW-1:0] fetch_pc_i, instr_pc_o;
  logic [31:0]   fetch_data_i, exp_instr_i, instr_o;
  logic [15:0]   exp_cinstr_o;
`ifdef BP_FE_REALIGN_PERF_EN
  logic [31:0]   perf_cinstr_o, perf_straddle_o;
`endif
  logic [73:0]   obs;

  int checks = 0;
  int errors = 0;

  bp_fe_instr_realigner dut (
    .clk_i(clk), .reset_i(reset_i),
    .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_data_i(fetch_data_i),
    .fetch_ready_o(fetch_ready_o), .redirect_v_i(redirect_v_i),
    .exp_cinstr_o(exp_cinstr_o), .exp_instr_i(exp_instr_i), .exp_v_i(exp_v_i),
    .instr_v_o(instr_v_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_compressed_o(instr_compressed_o),
`ifdef BP_FE_REALIGN_PERF_EN
    .perf_cinstr_o(perf_cinstr_o), .perf_straddle_o(perf_straddle_o),
`endif
    .instr_illegal_o(instr_illegal_o));

  // {valid, compressed, illegal, pc, instr}
  assign obs = {instr_v_o, instr_compressed_o, instr_illegal_o, instr_pc_o, instr_o};

  // Stand-in expander: a few real RVC encodings, 0x0000 illegal, everything else a fixed scramble.
  function automatic logic [32:0] expand(input logic [15:0] p);
    if (p == 16'h4505) return {1'b1, 32'h00100513};
    if (p == 16'h0001) return {1'b1, 32'h00000013};
    if (p == 16'h0000) return {1'b0, 32'h00000000};
    return {1'b1, p ^ 16'hA5A5, p};
  endfunction

  always_comb {exp_v_i, exp_instr_i} = expand(exp_cinstr_o);

  task automatic cyc(input logic rst, input logic fv, input logic [VW-1:0] pc,
                     input logic [31:0] d, input logic rdy, input logic redir);
    @(negedge clk);
    reset_i = rst; fetch_v_i = fv; fetch_pc_i = pc; fetch_data_i = d;
    instr_ready_i = rdy; redirect_v_i = redir;
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 39'h1000, 32'h00100093, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs !== 74'h0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs); end
    checks++;
    if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fetch_ready_o); end
`ifdef BP_FE_REALIGN_PERF_EN
    checks++;
    if ({perf_cinstr_o, perf_straddle_o} !== 64'h0) begin
      errors++; $display("FAIL reset_perf got %h/%h exp 0/0", perf_cinstr_o, perf_straddle_o);
    end
`endif
  endtask

  task automatic test_aligned();
    cyc(1'b1, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 39'h1000, 32'h00100093, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 39'h1000, 32'h00100093}) begin
      errors++; $display("FAIL aligned_out got %h", obs);
    end
    checks++;
    if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL aligned_ready got %b exp 1", fetch_ready_o); end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (instr_v_o !== 1'b0) begin errors++; $display("FAIL aligned_single got %b exp 0", instr_v_o); end
  endtask

  task automatic test_two_compressed();
    cyc(1'b1, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 39'h2000, 32'h00014505, 1'b1, 1'b0);
    checks++;
    if (exp_cinstr_o !== 16'h4505) begin errors++; $display("FAIL two_c_mux got %h exp 4505", exp_cinstr_o); end
    cyc(1'b0, 1'b1, 39'h2004, 32'h00100093, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 39'h2000, 32'h00100513}) begin
      errors++; $display("FAIL two_c_first got %h", obs);
    end
    checks++;
    if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL two_c_ready got %b exp 0", fetch_ready_o); end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 39'h2002, 32'h00000013}) begin
      errors++; $display("FAIL two_c_second got %h", obs);
    end
  endtask

  task automatic test_straddle();
    cyc(1'b1, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 39'h3000, 32'h00934505, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 39'h3004, 32'h45050010, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 39'h3000, 32'h00100513}) begin
      errors++; $display("FAIL straddle_first got %h", obs);
    end
    checks++;
    if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL straddle_ready got %b exp 1", fetch_ready_o); end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 39'h3002, 32'h00100093}) begin
      errors++; $display("FAIL straddle_stitch got %h", obs);
    end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 39'h3006, 32'h00100513}) begin
      errors++; $display("FAIL straddle_tail got %h", obs);
    end
`ifdef BP_FE_REALIGN_PERF_EN
    checks++;
    if ({perf_cinstr_o, perf_straddle_o} !== {32'd2, 32'd1}) begin
      errors++; $display("FAIL straddle_perf got %0d/%0d exp 2/1", perf_cinstr_o, perf_straddle_o);
    end
`endif
  endtask

  task automatic test_odd_entry();
    cyc(1'b1, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 39'h4002, 32'h45050000, 1'b1, 1'b0);
    checks++;
    if (exp_cinstr_o !== 16'h4505) begin errors++; $display("FAIL odd_mux got %h exp 4505", exp_cinstr_o); end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 39'h4002, 32'h00100513}) begin
      errors++; $display("FAIL odd_out got %h", obs);
    end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({instr_v_o, fetch_ready_o} !== 2'b01) begin
      errors++; $display("FAIL odd_single got v=%b rdy=%b exp v=0 rdy=1", instr_v_o, fetch_ready_o);
    end
  endtask

  task automatic test_backpressure_illegal();
    cyc(1'b1, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 39'h5000, 32'h00000000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 39'h5004, 32'h00100093, 1'b0, 1'b0);
      checks++;
      if ({obs, fetch_ready_o} !== {1'b1, 1'b1, 1'b1, 39'h5000, 32'h0, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d] got %h rdy=%b", i, obs, fetch_ready_o);
      end
    end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 39'h5002, 32'h0}) begin
      errors++; $display("FAIL bp_second got %h", obs);
    end
  endtask

  // Held uncompressed residue, then a flush (use_reset selects reset vs redirect).
  task automatic test_flush_mid_straddle(input logic use_reset);
    cyc(1'b1, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 39'h7002, 32'h00930000, 1'b1, 1'b0);
    cyc(use_reset, 1'b1, 39'h7004, 32'h45054505, 1'b1, !use_reset);
    checks++;
    if (fetch_ready_o !== use_reset) begin
      errors++; $display("FAIL flush_ready got %b exp %b", fetch_ready_o, use_reset);
    end
    cyc(1'b0, 1'b1, 39'h6000, 32'h00100093, 1'b1, 1'b0);
    checks++;
    if ({obs, fetch_ready_o} !== {74'h0, 1'b1}) begin
      errors++; $display("FAIL flush_clear got %h rdy=%b", obs, fetch_ready_o);
    end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 39'h6000, 32'h00100093}) begin
      errors++; $display("FAIL flush_next got %h", obs);
    end
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (instr_v_o !== 1'b0) begin errors++; $display("FAIL flush_drop_pending got %b exp 0", instr_v_o); end
  endtask

  function automatic logic [15:0] gen_parcel();
    logic [15:0] r;
    int k;
    r = 16'($urandom);
    k = $urandom_range(7);
    if (k == 0) r = 16'h0000;
    else if (k < 4) r[1:0] = 2'b11;
    else if (r[1:0] == 2'b11) r[0] = 1'b0;
    return r;
  endfunction

  // Scoreboard: accepted words become a parcel stream; instructions are carved off its head.
  task automatic test_random(input logic [VW-1:0] start, input int ncyc);
    logic [15:0]   pq_d[$];
    logic [VW-1:0] pq_pc[$];
    logic [73:0]   exp_q[$];
    logic [73:0]   e, prev_obs;
    logic [32:0]   x;
    logic [VW-1:0] pc_cur, base;
    logic [31:0]   word;
    logic          have, fv, rdy, prev_stall;
    int            ncomp, nstr;
    pc_cur = start; have = 1'b0; prev_stall = 1'b0; prev_obs = '0; ncomp = 0; nstr = 0; word = '0;
    cyc(1'b1, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < ncyc + 24; i++) begin
      if (!have) begin word = {gen_parcel(), gen_parcel()}; have = 1'b1; end
      fv  = have && ($urandom_range(3) != 0) && (i < ncyc);
      rdy = ($urandom_range(3) != 0) || (i >= ncyc);
      cyc(1'b0, fv, pc_cur, word, rdy, 1'b0);
      if (prev_stall) begin
        checks++;
        if (obs !== prev_obs) begin errors++; $display("FAIL rand_stable got %h exp %h", obs, prev_obs); end
      end
      if (instr_v_o && instr_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected got %h exp none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL rand_out got %h exp %h", obs, e); end
        end
      end
      if (fv && fetch_ready_o) begin
        base = {pc_cur[VW-1:2], 2'b00};
        if (!pc_cur[1]) begin pq_d.push_back(word[15:0]); pq_pc.push_back(base); end
        pq_d.push_back(word[31:16]); pq_pc.push_back(base + 39'd2);
        while (pq_d.size() > 0) begin
          if (pq_d[0][1:0] != 2'b11) begin
            x = expand(pq_d[0]);
            exp_q.push_back({1'b1, 1'b1, !x[32], pq_pc[0], x[31:0]});
            ncomp++;
            void'(pq_d.pop_front()); void'(pq_pc.pop_front());
          end else if (pq_d.size() >= 2) begin
            exp_q.push_back({1'b1, 1'b0, 1'b0, pq_pc[0], pq_d[1], pq_d[0]});
            nstr++;
            void'(pq_d.pop_front()); void'(pq_pc.pop_front());
            void'(pq_d.pop_front()); void'(pq_pc.pop_front());
          end else begin
            break;
          end
        end
        pc_cur = base + 39'd4;
        have = 1'b0;
      end
      prev_stall = instr_v_o && !instr_ready_i;
      prev_obs = obs;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d exp 0", exp_q.size()); end
`ifdef BP_FE_REALIGN_PERF_EN
    checks++;
    if ({perf_cinstr_o, perf_straddle_o} !== {32'(ncomp), 32'(nstr)}) begin
      errors++; $display("FAIL rand_perf got %0d/%0d exp %0d/%0d", perf_cinstr_o, perf_straddle_o, ncomp, nstr);
    end
`endif
  endtask

  initial begin
    reset_i = 1'b1; fetch_v_i = 1'b0; fetch_pc_i = '0; fetch_data_i = '0;
    instr_ready_i = 1'b1; redirect_v_i = 1'b0;
    test_reset();
    test_aligned();
    test_two_compressed();
    test_straddle();
    test_odd_entry();
    test_backpressure_illegal();
    test_flush_mid_straddle(1'b0);
    test_flush_mid_straddle(1'b1);
    test_random({7'($urandom), 30'($urandom), 2'b00}, 600);
    test_random(39'h7F_FFFF_FFFA, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_instr_realigner.md
Name: bp_fe_instr_realigner

Overview:
- Front-end sequencer between the I-cache fetch word stream and the RVC expander.
- Splits each aligned 32-bit fetch word into 16-bit parcels and drives the combinational expander one parcel at a time.
- Stitches 32-bit instructions that straddle fetch-word boundaries.
- Emits exactly one 32-bit instruction per valid/ready handshake, with its PC, to the BE-facing queue.

Parameters:
- vaddr_width_p, 39, virtual PC width.
- instr_width_p, 32, uncompressed instruction width; parcel width is instr_width_p/2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- fetch_v_i  in  1  fetch word valid.
- fetch_pc_i  in  vaddr_width_p  PC of the fetch word; bit[0]=0, bit[1] selects the start parcel.
- fetch_data_i  in  32  fetch word; parcel0=[15:0], parcel1=[31:16].
- fetch_ready_o  out  1  fetch word accepted when fetch_v_i&fetch_ready_o.
- redirect_v_i  in  1  flush: PC redirect from BE/branch predictor.
- exp_cinstr_o  out  16  parcel to the expander.
- exp_instr_i  in  32  expander result.
- exp_v_i  in  1  expander legal flag.
- instr_v_o  out  1  output instruction valid.
- instr_ready_i  in  1  consumer ready.
- instr_o  out  32  expanded or passthrough instruction.
- instr_pc_o  out  vaddr_width_p  PC of instr_o.
- instr_compressed_o  out  1  instr_o came from a 16-bit parcel.
- instr_illegal_o  out  1  compressed parcel rejected by the expander (exp_v_i=0).

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous and active-high. On reset all outputs and registers are 0 and the state is EMPTY.
- Parcel classification: a parcel is compressed iff parcel[1:0]!=2'b11.
- State: EMPTY, or RESID holding resid_q[15:0] and resid_pc_q.
- Output register:
  - adv = !instr_v_o | instr_ready_i.
  - The output register loads only when adv=1.
  - Latency is 1 cycle from parcel selection to instr_v_o.
  - Outputs stay stable while instr_v_o & !instr_ready_i.
- EMPTY, fetch accepted, pc[1]=0:
  - parcel0 compressed: output exp_instr_i at pc; resid_q<=parcel1, resid_pc_q<=pc+2; go to RESID.
  - parcel0 not compressed: output fetch_data_i at pc; stay EMPTY.
- EMPTY, fetch accepted, pc[1]=1:
  - parcel1 compressed: output exp_instr_i at pc; stay EMPTY.
  - parcel1 not compressed: no output; resid_q<=parcel1, resid_pc_q<=pc; go to RESID.
- RESID with resid_q compressed:
  - fetch_ready_o=0.
  - On adv: output exp_instr_i at resid_pc_q; go to EMPTY.
- RESID with resid_q not compressed:
  - fetch_ready_o=adv. On accept: output {fetch_data_i[15:0],resid_q} at resid_pc_q.
  - resid_q<=parcel1, resid_pc_q<=resid_pc_q+4; stay in RESID.
  - fetch_pc_i is not checked; a sequential stream is the caller's contract.
- exp_cinstr_o mux: resid_q in RESID; otherwise parcel0 or parcel1 per fetch_pc_i[1]. Driven every cycle.
- fetch_ready_o = adv & !redirect_v_i & !(RESID & resid compressed).
- Compressed outputs: instr_illegal_o=!exp_v_i, instr_compressed_o=1. For an illegal parcel, instr_o=exp_instr_i (0).
- PC arithmetic: modulo 2^vaddr_width_p.
- Redirect:
  - redirect_v_i=1 in a cycle clears instr_v_o and the residue and goes to EMPTY at the next edge.
  - Any fetch or handshake in that cycle is dropped.
  - Redirect has priority over every other event; reset has priority over redirect.
- Reset mid-straddle: the held residue is discarded and no partial instruction is emitted.

Optional Feature:
- Macro: BP_FE_REALIGN_PERF_EN.
- When defined, adds output ports perf_cinstr_o[31:0] and perf_straddle_o[31:0]:
  - perf_cinstr_o counts emitted compressed instructions.
  - perf_straddle_o counts emitted stitched instructions.
  - Both counters reset to 0, are not cleared by redirect, and wrap at 2^32.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Aligned 32-bit: pc 0x1000, data 0x00100093, instr_ready_i=1 -> next cycle instr_o=0x00100093, pc=0x1000, compressed=0; stays EMPTY.
- Two compressed in one word: pc 0x2000, data 0x00014505 -> 0x00100513 @0x2000, then 0x00000013 @0x2002. fetch_ready_o=0 during the second cycle.
- Straddle: pc 0x3000 data 0x00934505, then pc 0x3004 data 0x45050010. Required outputs:
  - 0x00100513 @0x3000, compressed=1
  - 0x00100093 @0x3002, compressed=0
  - 0x00100513 @0x3006
  - With the feature enabled, perf_straddle_o=1.
- Odd entry: pc 0x4002, data 0x45050000 -> single output 0x00100513 @0x4002; parcel0 is ignored.
- Backpressure and illegal parcel: data 0x00000000 at pc 0x5000 with instr_ready_i=0 for 3 cycles:
  - instr_v_o=1, instr_illegal_o=1, pc=0x5000 held stable.
  - fetch_ready_o=0 throughout.
- Redirect mid-straddle: residue 0x0093 held, then redirect_v_i=1, then fetch pc 0x6000 data 0x00100093 -> only 0x00100093 @0x6000 is emitted. Reset in the same state gives identical results with all outputs at 0.
